// File: rtl/modbus_pkg.sv
// ---------------------------------------------------------------------------
// modbus_pkg
// Shared definitions for the Modbus RTU receive and transmit framers.
//   rx_state_e  : one-hot (5-bit) state encoding of the frame receiver
//   CRC_INIT    : CRC-16/MODBUS seed value
//   CRC_POLY    : reflected CRC-16/MODBUS polynomial
//   BCAST_ADDR  : broadcast station address, always accepted
//   MIN_FRAME   : shortest legal frame in bytes (address + function + CRC)
// ---------------------------------------------------------------------------
package modbus_pkg;

  // One-hot state encoding for the receive FSM.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_RECV  = 5'b00010,
    ST_DROP  = 5'b00100,
    ST_CHECK = 5'b01000,
    ST_HOLD  = 5'b10000
  } rx_state_e;

  localparam logic [15:0] CRC_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC_POLY   = 16'hA001;
  localparam logic [7:0]  BCAST_ADDR = 8'h00;
  localparam int          MIN_FRAME  = 4;

endpackage : modbus_pkg

// File: rtl/modbus_crc16.sv
// ---------------------------------------------------------------------------
// modbus_crc16
// Purely combinational CRC-16/MODBUS byte step: folds one byte into a
// running CRC value, LSB first, using the reflected polynomial.  Shared by
// the receive framer and the transmit framer.
// Ports:
//   crc_in   in  16  running CRC before this byte
//   data_in  in   8  byte to fold in
//   crc_out  out 16  running CRC after this byte
// ---------------------------------------------------------------------------
module modbus_crc16
  import modbus_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc_v;

  // Eight unrolled shift/xor steps; the whole byte is absorbed in one cycle.
  always_comb begin
    crc_v = crc_in ^ {8'h00, data_in};
    for (int i = 0; i < 8; i++) begin
      if (crc_v[0]) begin
        crc_v = (crc_v >> 1) ^ CRC_POLY;
      end else begin
        crc_v = crc_v >> 1;
      end
    end
    crc_out = crc_v;
  end

endmodule : modbus_crc16

// File: rtl/modbus_frame_rx.sv
// ---------------------------------------------------------------------------
// modbus_frame_rx
// Modbus RTU frame assembler.  Collects bytes from the UART receiver into a
// local buffer between frame boundaries, checks length, CRC and station
// address, and holds an accepted frame for the protocol engine until it is
// acknowledged.  Rejected frames raise one-cycle error pulses.
//
// Build option:
//   MODBUS_CRC_CHECK_EN  defined     -> CRC engine built, residue checked
//                        not defined -> no CRC logic, err_crc tied to 0,
//                                       last two bytes still treated as CRC
//
// Parameters:
//   MAX_LEN     buffer depth in bytes including CRC (power of two)
//   SLAVE_ADDR  own station address (8'h00 always accepted as broadcast)
// Ports:
//   clk_in, rst_in      clock, asynchronous active-high reset
//   rx_data, rx_done    received byte and its one-cycle strobe
//   rx_drop_frame       inter-character gap violation, frame is corrupt
//   rx_frame_end        end-of-frame idle detected
//   frame_valid         accepted frame held in buffer
//   frame_len           payload length (address..data), CRC excluded
//   frame_bcast         held frame is a broadcast
//   frame_ack           consumer releases the held frame
//   rd_addr, rd_data    buffer read port, 1-cycle registered latency
//   err_crc, err_len, err_ovf, err_drop   one-cycle error pulses
// ---------------------------------------------------------------------------
module modbus_frame_rx
  import modbus_pkg::*;
#(
  parameter int         MAX_LEN    = 256,
  parameter logic [7:0] SLAVE_ADDR = 8'h01
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_done,
  input  logic                       rx_drop_frame,
  input  logic                       rx_frame_end,
  output logic                       frame_valid,
  output logic [$clog2(MAX_LEN):0]   frame_len,
  output logic                       frame_bcast,
  input  logic                       frame_ack,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data,
  output logic                       err_crc,
  output logic                       err_len,
  output logic                       err_ovf,
  output logic                       err_drop
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = AW + 1;

  rx_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]  addr_q, addr_d;
  logic        frame_valid_q, frame_valid_d;
  logic [CW-1:0] frame_len_q, frame_len_d;
  logic        frame_bcast_q, frame_bcast_d;
  logic        err_crc_q, err_crc_d;
  logic        err_len_q, err_len_d;
  logic        err_ovf_q, err_ovf_d;
  logic        err_drop_q, err_drop_d;
  logic [7:0]  rd_data_q;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          crc_bad;

  logic [7:0] mem [MAX_LEN];

`ifdef MODBUS_CRC_CHECK_EN
  logic [15:0] crc_q, crc_d;
  logic [15:0] crc_base;
  logic [15:0] crc_next;

  // The first byte of a frame is folded into the fixed seed, so a stale
  // value left over from a previous frame never matters.
  assign crc_base = (state_q == ST_IDLE) ? CRC_INIT : crc_q;

  modbus_crc16 u_crc (
    .crc_in  (crc_base),
    .data_in (rx_data),
    .crc_out (crc_next)
  );

  // The CRC advances exactly when a byte is written into the buffer; the
  // residue tested on entry to CHECK therefore already includes a byte that
  // arrives together with the end-of-frame pulse.
  always_comb begin
    crc_d   = wr_en ? crc_next : crc_q;
    crc_bad = (crc_d != 16'h0000);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end
`else
  assign crc_bad = 1'b0;
`endif

  // Next-state and output logic.  Length and CRC verdicts are computed while
  // leaving RECV and registered, so err_len/err_crc are high during the
  // CHECK cycle and CHECK itself only has to look at the address.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    addr_d        = addr_q;
    frame_valid_d = frame_valid_q;
    frame_len_d   = frame_len_q;
    frame_bcast_d = frame_bcast_q;
    err_crc_d     = 1'b0;
    err_len_d     = 1'b0;
    err_ovf_d     = 1'b0;
    err_drop_d    = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = count_q[AW-1:0];

    unique case (state_q)
      ST_IDLE: begin
        if (rx_done) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          count_d = CW'(1);
          addr_d  = rx_data;
          state_d = ST_RECV;
        end
      end

      ST_RECV: begin
        if (rx_drop_frame) begin
          err_drop_d = 1'b1;
          state_d    = ST_DROP;
        end else if (rx_done && (count_q == CW'(MAX_LEN))) begin
          err_ovf_d = 1'b1;
          state_d   = ST_DROP;
        end else begin
          if (rx_done) begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
          end
          if (rx_frame_end) begin
            state_d   = ST_CHECK;
            err_len_d = (count_d < CW'(MIN_FRAME));
            err_crc_d = !err_len_d && crc_bad;
          end
        end
      end

      ST_DROP: begin
        if (rx_frame_end) begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      end

      ST_CHECK: begin
        state_d = ST_IDLE;
        count_d = '0;
        // Frames for other stations are dropped without any error.
        if (!err_len_q && !err_crc_q &&
            ((addr_q == SLAVE_ADDR) || (addr_q == BCAST_ADDR))) begin
          state_d       = ST_HOLD;
          frame_valid_d = 1'b1;
          frame_len_d   = count_q - CW'(2);
          frame_bcast_d = (addr_q == BCAST_ADDR);
        end
      end

      ST_HOLD: begin
        if (frame_ack) begin
          state_d       = ST_IDLE;
          frame_valid_d = 1'b0;
          frame_len_d   = '0;
          frame_bcast_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // State and output registers; a reset mid-frame simply returns to IDLE
  // with every pulse cleared.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      addr_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= '0;
      frame_bcast_q <= 1'b0;
      err_crc_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_drop_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      addr_q        <= addr_d;
      frame_valid_q <= frame_valid_d;
      frame_len_q   <= frame_len_d;
      frame_bcast_q <= frame_bcast_d;
      err_crc_q     <= err_crc_d;
      err_len_q     <= err_len_d;
      err_ovf_q     <= err_ovf_d;
      err_drop_q    <= err_drop_d;
    end
  end

  // Frame buffer write port (simple dual-port RAM, no reset on contents).
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= rx_data;
    end
  end

  // Registered read port, usable in every state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_len   = frame_len_q;
  assign frame_bcast = frame_bcast_q;
  assign rd_data     = rd_data_q;
  assign err_len     = err_len_q;
  assign err_ovf     = err_ovf_q;
  assign err_drop    = err_drop_q;
`ifdef MODBUS_CRC_CHECK_EN
  assign err_crc     = err_crc_q;
`else
  assign err_crc     = 1'b0;
`endif

endmodule : modbus_frame_rx

// File: tb/tb_modbus_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_modbus_frame_rx
// Directed and randomized frames against a byte-queue reference model of the
// frame receiver.  The model decides accept/reject from the frame contents
// (length, bit-serial CRC residue, station address) and the buffer contents
// are read back through the read port while a frame is held.
// ---------------------------------------------------------------------------
module tb_modbus_frame_rx;

  localparam int         MAX_LEN   = 16;
  localparam int         AW        = $clog2(MAX_LEN);
  localparam logic [7:0] SLAVE     = 8'h01;
  localparam int         MIN_FRAME = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          rx_drop_frame;
  logic          rx_frame_end;
  logic          frame_valid;
  logic [AW:0]   frame_len;
  logic          frame_bcast;
  logic          frame_ack;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          err_crc;
  logic          err_len;
  logic          err_ovf;
  logic          err_drop;

  int total = 0;
  int bad   = 0;

  logic [7:0] frame_q[$];

  modbus_frame_rx #(
    .MAX_LEN    (MAX_LEN),
    .SLAVE_ADDR (SLAVE)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rx_data       (rx_data),
    .rx_done       (rx_done),
    .rx_drop_frame (rx_drop_frame),
    .rx_frame_end  (rx_frame_end),
    .frame_valid   (frame_valid),
    .frame_len     (frame_len),
    .frame_bcast   (frame_bcast),
    .frame_ack     (frame_ack),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .err_crc       (err_crc),
    .err_len       (err_len),
    .err_ovf       (err_ovf),
    .err_drop      (err_drop)
  );

  // Free-running clock; all stimulus and sampling happens on falling edges.
  always #5 clk_in = ~clk_in;

  // Safety net so the run always terminates.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation still running after time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Bit-serial reflected CRC-16/MODBUS over the whole queue.  A frame with
  // its CRC appended low byte first yields a residue of zero.
  function automatic logic [15:0] crcOf();
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    foreach (frame_q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = r[0] ^ frame_q[i][b];
        r  = r >> 1;
        if (fb) r = r ^ 16'hA001;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input bit withEnd);
    rx_data      = b;
    rx_done      = 1'b1;
    rx_frame_end = withEnd;
    @(negedge clk_in);
    rx_data      = 8'h00;
    rx_done      = 1'b0;
    rx_frame_end = 1'b0;
  endtask

  task automatic pulseEnd();
    rx_frame_end = 1'b1;
    @(negedge clk_in);
    rx_frame_end = 1'b0;
  endtask

  // Sends the queued frame; the end-of-frame pulse either rides on the last
  // byte or follows it one cycle later.
  task automatic applyStimulus(input bit endWithLast);
    int n;
    n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      sendByte(frame_q[i], endWithLast && (i == n - 1));
    end
    if (!endWithLast) pulseEnd();
  endtask

  task automatic buildGood(input logic [7:0] addr, input int plen);
    logic [15:0] c;
    frame_q.delete();
    frame_q.push_back(addr);
    for (int i = 0; i < plen; i++) frame_q.push_back(8'($urandom));
    c = crcOf();
    frame_q.push_back(c[7:0]);
    frame_q.push_back(c[15:8]);
  endtask

  task automatic readBack(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      rd_addr = AW'(i);
      @(negedge clk_in);
      checkOutput({tag, ".rd_data"}, 32'(rd_data), 32'(frame_q[i]));
    end
  endtask

  // Sends frame_q and checks the receiver's verdict against the model.
  task automatic checkFrame(input string tag, input bit endWithLast, input bit holdJunk);
    int         n;
    bit         lenErr, crcOk, crcErr, accept;
    logic [7:0] adr;
    n      = frame_q.size();
    adr    = frame_q[0];
    lenErr = (n < MIN_FRAME);
`ifdef MODBUS_CRC_CHECK_EN
    crcOk  = (crcOf() == 16'h0000);
`else
    crcOk  = 1'b1;
`endif
    crcErr = !lenErr && !crcOk;
    accept = !lenErr && crcOk && ((adr == SLAVE) || (adr == 8'h00));

    applyStimulus(endWithLast);
    checkOutput({tag, ".err_len"}, 32'(err_len), 32'(lenErr));
    checkOutput({tag, ".err_crc"}, 32'(err_crc), 32'(crcErr));
    checkOutput({tag, ".valid_check_cycle"}, 32'(frame_valid), 32'h0);
    @(negedge clk_in);
    checkOutput({tag, ".frame_valid"}, 32'(frame_valid), 32'(accept));
    checkOutput({tag, ".err_len_clear"}, 32'(err_len), 32'h0);
    if (accept) begin
      checkOutput({tag, ".frame_len"}, 32'(frame_len), 32'(n - 2));
      checkOutput({tag, ".frame_bcast"}, 32'(frame_bcast), 32'(adr == 8'h00));
      readBack(tag, n);
      if (holdJunk) begin
        for (int i = 0; i < 4; i++) sendByte(8'($urandom), 1'b0);
        pulseEnd();
        @(negedge clk_in);
        checkOutput({tag, ".hold_valid"}, 32'(frame_valid), 32'h1);
        checkOutput({tag, ".hold_len"}, 32'(frame_len), 32'(n - 2));
        checkOutput({tag, ".hold_err"}, 32'({err_len, err_crc, err_ovf, err_drop}), 32'h0);
        readBack({tag, ".hold"}, n);
      end
      frame_ack = 1'b1;
      @(negedge clk_in);
      frame_ack = 1'b0;
      checkOutput({tag, ".valid_after_ack"}, 32'(frame_valid), 32'h0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".frame_valid"}, 32'(frame_valid), 32'h0);
    checkOutput({tag, ".frame_len"}, 32'(frame_len), 32'h0);
    checkOutput({tag, ".frame_bcast"}, 32'(frame_bcast), 32'h0);
    checkOutput({tag, ".errors"}, 32'({err_crc, err_len, err_ovf, err_drop}), 32'h0);
    checkOutput({tag, ".rd_data"}, 32'(rd_data), 32'h0);
  endtask

  initial begin
    int kind;
    int idx;
    rst_in        = 1'b1;
    rx_data       = 8'h00;
    rx_done       = 1'b0;
    rx_drop_frame = 1'b0;
    rx_frame_end  = 1'b0;
    frame_ack     = 1'b0;
    rd_addr       = '0;

    // Reset state.
    repeat (3) @(negedge clk_in);
    checkAllZero("reset");
    rst_in = 1'b0;
    @(negedge clk_in);

    // Reference frame from the protocol: read holding register 0, count 1.
    frame_q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    checkFrame("ref_frame", 1'b0, 1'b0);

    // Same frame with a corrupted CRC byte, then a good frame.
    frame_q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0B};
    checkFrame("bad_crc", 1'b0, 1'b0);
    buildGood(SLAVE, 4);
    checkFrame("after_bad_crc", 1'b0, 1'b0);

    // Foreign station, then broadcast.
    buildGood(8'h07, 4);
    checkFrame("other_addr", 1'b0, 1'b0);
    checkOutput("other_addr.no_err", 32'({err_crc, err_len, err_ovf, err_drop}), 32'h0);
    buildGood(8'h00, 3);
    checkFrame("bcast", 1'b1, 1'b0);

    // Too short.
    frame_q = '{8'h01, 8'h03, 8'h00};
    checkFrame("short", 1'b0, 1'b0);

    // Gap violation after byte 2; the rest of the frame is thrown away.
    sendByte(8'h01, 1'b0);
    sendByte(8'h03, 1'b0);
    rx_drop_frame = 1'b1;
    rx_frame_end  = 1'b1;
    @(negedge clk_in);
    rx_drop_frame = 1'b0;
    rx_frame_end  = 1'b0;
    checkOutput("drop.err_drop", 32'(err_drop), 32'h1);
    sendByte(8'h00, 1'b0);
    checkOutput("drop.pulse_width", 32'(err_drop), 32'h0);
    sendByte(8'h00, 1'b0);
    sendByte(8'h84, 1'b0);
    pulseEnd();
    checkOutput("drop.no_len_err", 32'({err_len, err_crc}), 32'h0);
    @(negedge clk_in);
    checkOutput("drop.no_valid", 32'(frame_valid), 32'h0);
    buildGood(SLAVE, 2);
    checkFrame("after_drop", 1'b0, 1'b0);

    // Largest legal frame fills the buffer exactly.
    buildGood(SLAVE, MAX_LEN - 3);
    checkFrame("max_len", 1'b0, 1'b0);

    // One byte too many.
    for (int i = 0; i <= MAX_LEN; i++) begin
      sendByte(8'($urandom), 1'b0);
      if (i == MAX_LEN - 1) checkOutput("ovf.not_yet", 32'(err_ovf), 32'h0);
      if (i == MAX_LEN)     checkOutput("ovf.err_ovf", 32'(err_ovf), 32'h1);
    end
    sendByte(8'h55, 1'b0);
    checkOutput("ovf.pulse_width", 32'(err_ovf), 32'h0);
    pulseEnd();
    checkOutput("ovf.no_len_err", 32'(err_len), 32'h0);
    @(negedge clk_in);
    checkOutput("ovf.no_valid", 32'(frame_valid), 32'h0);

    // Bytes arriving while a frame is held leave the buffer untouched.
    buildGood(SLAVE, 4);
    checkFrame("hold", 1'b0, 1'b1);

    // Reset in the middle of a frame.
    sendByte(8'h01, 1'b0);
    sendByte(8'h03, 1'b0);
    sendByte(8'h00, 1'b0);
    rst_in = 1'b1;
    #1;
    checkAllZero("mid_reset");
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    checkOutput("mid_reset.errors_after", 32'({err_crc, err_len, err_ovf, err_drop}), 32'h0);
    buildGood(SLAVE, 4);
    checkFrame("after_reset", 1'b0, 1'b0);

    // Randomized frame mix.
    for (int t = 0; t < 24; t++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0: buildGood(SLAVE, int'($urandom_range(1, 10)));
        1: buildGood(8'h00, int'($urandom_range(1, 10)));
        2: buildGood(8'($urandom_range(2, 255)), int'($urandom_range(1, 10)));
        3: begin
          buildGood(SLAVE, int'($urandom_range(1, 10)));
          idx = int'($urandom_range(0, frame_q.size() - 1));
          frame_q[idx] = frame_q[idx] ^ 8'(1 << $urandom_range(0, 7));
        end
        default: begin
          frame_q.delete();
          repeat ($urandom_range(1, 3)) frame_q.push_back(8'($urandom));
        end
      endcase
      checkFrame("rand", 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_modbus_frame_rx

// File: doc/modbus_frame_rx.md
# modbus_frame_rx

Modbus RTU frame assembler sitting directly downstream of `uart_byte_rx` and `ct_15t_gen`. It collects received bytes into an internal buffer between frame boundaries and runs a byte-wise CRC-16/MODBUS. A frame that passes the drop, length, address and CRC checks is presented to the slave protocol engine through a hold/acknowledge handshake and a random-access read port. Bad frames are discarded and flagged with one-cycle error pulses.

## Interface
- `MAX_LEN`, default 256: buffer depth in bytes, including the CRC bytes; power of two.
- `SLAVE_ADDR`, default 8'h01: own station address; address 8'h00 is always accepted as broadcast.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset; one clock, asynchronous assert, active-high.
- `rx_data`  in  8  received byte; valid while `rx_done` is high.
- `rx_done`  in  1  one-cycle pulse per received byte.
- `rx_drop_frame`  in  1  pulse from `ct_15t_gen`: the current frame is corrupt (gap > 1.5T).
- `rx_frame_end`  in  1  pulse from the 3.5T idle detector: the frame is complete.
- `frame_valid`  out  1  an accepted frame is held in the buffer.
- `frame_len`  out  $clog2(MAX_LEN)+1  payload length (address through data), excluding the CRC.
- `frame_bcast`  out  1  the accepted frame is addressed to 8'h00.
- `frame_ack`  in  1  consumer releases the buffer.
- `rd_addr`  in  $clog2(MAX_LEN)  buffer read index.
- `rd_data`  out  8  buffer byte at `rd_addr`, registered, 1-cycle latency.
- `err_crc`, `err_len`, `err_ovf`, `err_drop`  out  1 each  one-cycle error pulses.

## Operation
- FSM states are IDLE, RECV, DROP, CHECK and HOLD.
- **IDLE**
  - On `rx_done`: write byte to buffer[0], set count to 1, seed CRC with 0xFFFF folded with the byte, go to RECV.
  - `rx_drop_frame` and `rx_frame_end` are ignored.
- **RECV**
  - Each `rx_done` writes buffer[count], increments count and updates the CRC (poly 0xA001, reflected, LSB-first, one byte per cycle).
  - If `rx_done` arrives with count == MAX_LEN: pulse `err_ovf`, go to DROP.
  - `rx_drop_frame`: pulse `err_drop`, go to DROP.
  - `rx_frame_end`: go to CHECK.
  - Simultaneous `rx_done` and `rx_frame_end`: the byte is stored first, then go to CHECK.
  - Simultaneous `rx_drop_frame` and `rx_frame_end`: the drop wins.
- **DROP**
  - Discard all bytes.
  - On `rx_frame_end` return to IDLE with count cleared.
- **CHECK** (single cycle; checks are applied in this priority order)
  - count < 4: pulse `err_len`, go to IDLE.
  - CRC residue != 16'h0000: pulse `err_crc`, go to IDLE.
  - buffer[0] not equal to `SLAVE_ADDR` and not 8'h00: go to IDLE silently, no error.
  - Otherwise: `frame_len` = count−2, set `frame_bcast`, go to HOLD.
- **HOLD**
  - `frame_valid` = 1; the buffer is frozen.
  - Incoming `rx_done` bytes are ignored. Frames arriving during HOLD are lost without error.
  - `frame_ack` returns to IDLE.
  - `frame_ack` outside HOLD is ignored.
- The read port is usable in any state; contents are guaranteed only in HOLD.

## Timing
- Reset values:
  - All outputs 0; `rd_data` = 8'h00.
  - FSM in IDLE, count 0, CRC 16'hFFFF.
  - Buffer contents undefined.
- Reset mid-frame aborts immediately; no error pulse is issued.
- `rx_frame_end` to `frame_valid` high: 2 cycles (RECV→CHECK, CHECK→HOLD).
- Error pulses are 1 cycle wide. `err_len`/`err_crc` fire in the CHECK cycle; `err_ovf`/`err_drop` fire in the cycle after the causing input.
- `frame_valid` drops the cycle after `frame_ack` is sampled high.
- A new frame may begin on the cycle `frame_valid` drops.
- `frame_len` and `frame_bcast` stay stable throughout HOLD.
- CRC update completes within the same cycle as the `rx_done` write; no back-pressure is needed, since bytes are ≥ 1 character time apart.

## Configuration
- `MODBUS_CRC_CHECK_EN` defined: CRC engine instantiated; CHECK evaluates the residue.
- Not defined:
  - No CRC logic is built.
  - `err_crc` is tied to 0.
  - The residue test always passes.
  - The last 2 bytes are still treated as CRC and excluded from `frame_len`.

## Structure
- Shared package `modbus_pkg` holds:
  - the state encoding constants (one-hot, 5 bits);
  - `CRC_INIT` 16'hFFFF and `CRC_POLY` 16'hA001;
  - `BCAST_ADDR` 8'h00;
  - `MIN_FRAME` 4.
- Sub-module `modbus_crc16`: combinational next-CRC from (crc_in[15:0], byte[7:0]). It is reused later by the TX framer.
- Buffer is an inferred simple dual-port RAM inside this block.

## Test plan
- Frame 01 03 00 00 00 01 84 0A, then `rx_frame_end` → `frame_valid`=1 two cycles later, `frame_len`=6, `frame_bcast`=0, rd_addr 1 → `rd_data` 8'h03.
- Same frame with last byte 0B → `err_crc` pulse, `frame_valid` stays 0, next good frame accepted.
- Frame with address 8'h07 and valid CRC → no `frame_valid`, no error pulse; address 8'h00 with valid CRC → `frame_valid`, `frame_bcast`=1.
- 3 bytes then `rx_frame_end` → `err_len`; `rx_drop_frame` after byte 2 → `err_drop`, remaining bytes ignored until `rx_frame_end`, then IDLE.
- MAX_LEN+1 bytes → `err_ovf` on the extra byte; bytes arriving while in HOLD do not change buffer[0..5]; `frame_ack` → `frame_valid` falls next cycle.
- Assert `rst_in` mid-RECV → all outputs 0; a subsequent good frame is accepted normally.
